fifo_sync_ctl: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr_wrap.sv | 17 +
 rtl/fifo_sync_ctl.sv | 98 +++++++++
 tb/tb_fifo_sync_ctl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, helpers and status bundle for the synchronous FIFO family
package fifo_pkg;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction
   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;
endpackage

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: DEPTH-modulo pointer with increment enable and explicit wrap to zero
module fifo_ptr_wrap
   import fifo_pkg::*;
#(
   parameter int DEPTH = 5,
   localparam int PW = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);
   logic [PW-1:0] ptr_q, ptr_d;
   always_comb ptr_d = !inc ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
   assign ptr = ptr_q;
endmodule

// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl: single-clock FIFO with any depth, level/threshold flags, sticky errors and
// either first-word-fall-through or registered read output
module fifo_sync_ctl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 5,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter bit OUT_REG    = 1'b0,
   localparam int LW = level_width(DEPTH),
   localparam int PW = clog2_min1(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] d_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  d_valid,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [LW-1:0]         level,
   output logic                  overflow,
   output logic                  underflow
);
   if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
      $error("fifo_sync_ctl: illegal DEPTH/AF_THRESH/AE_THRESH");
   end
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [LW-1:0] count_q, count_d;
   logic ovf_q, ovf_d, unf_q, unf_d;
   logic push_ok, pop_ok;
   logic [PW-1:0] wr_ptr, rd_ptr;
   fifo_status_t st;
   // a full FIFO still takes a push when the same cycle frees a slot; an empty one never bypasses
   always_comb begin
      pop_ok  = pop && (count_q != '0);
      push_ok = push && ((count_q != LW'(DEPTH)) || pop_ok);
      count_d = count_q + LW'(push_ok) - LW'(pop_ok);
      ovf_d   = ovf_q || (push && !push_ok);
      unf_d   = unf_q || (pop && !pop_ok);
      mem_d   = mem_q;
      if (push_ok) mem_d[wr_ptr] = d_in;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         mem_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         mem_q   <= mem_d;
      end
   end
   fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push_ok), .ptr(wr_ptr));
   fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop_ok), .ptr(rd_ptr));
   always_comb begin
      st.empty        = count_q == '0;
      st.full         = count_q == LW'(DEPTH);
      st.almost_full  = count_q >= LW'(AF_THRESH);
      st.almost_empty = count_q <= LW'(AE_THRESH);
      st.overflow     = ovf_q;
      st.underflow    = unf_q;
   end
   assign empty        = st.empty;
   assign full         = st.full;
   assign almost_full  = st.almost_full;
   assign almost_empty = st.almost_empty;
   assign overflow     = st.overflow;
   assign underflow    = st.underflow;
   assign level        = count_q;
   if (OUT_REG) begin : g_reg_out
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic dval_q, dval_d;
      always_comb begin
         dout_d = pop_ok ? mem_q[rd_ptr] : dout_q;
         dval_d = pop_ok;
      end
      always_ff @(posedge clk) begin
         dout_q <= rst ? '0 : dout_d;
         dval_q <= rst ? 1'b0 : dval_d;
      end
      assign d_out   = dout_q;
      assign d_valid = dval_q;
   end else begin : g_fwft_out
      assign d_out   = st.empty ? '0 : mem_q[rd_ptr];
      assign d_valid = !st.empty;
   end
   a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= LW'(DEPTH));
   a_refused_push: assert property (@(posedge clk) disable iff (rst) (push && !push_ok) |=> $stable(count_q));
endmodule

// File: tb/tb_fifo_sync_ctl.sv
// tb_fifo_sync_ctl: directed stimulus into FWFT and registered-output FIFOs, scoreboarded read data
module tb_fifo_sync_ctl;
   logic clk = 1'b0, rst, push, pop;
   logic [7:0] d_in, do0, do1;
   logic dv0, dv1, em0, em1, fu0, fu1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
   logic [2:0] lv0, lv1;
   int total = 0, bad = 0;
   logic [7:0] q0[$], q1[$];

   always #5 clk = ~clk;

   fifo_sync_ctl #(.DATA_WIDTH(8), .DEPTH(5), .OUT_REG(1'b0)) u_fwft (
      .clk(clk), .rst(rst), .push(push), .d_in(d_in), .pop(pop), .d_out(do0), .d_valid(dv0),
      .empty(em0), .full(fu0), .almost_full(af0), .almost_empty(ae0), .level(lv0),
      .overflow(ov0), .underflow(un0));
   fifo_sync_ctl #(.DATA_WIDTH(8), .DEPTH(5), .OUT_REG(1'b1)) u_reg (
      .clk(clk), .rst(rst), .push(push), .d_in(d_in), .pop(pop), .d_out(do1), .d_valid(dv1),
      .empty(em1), .full(fu1), .almost_full(af1), .almost_empty(ae1), .level(lv1),
      .overflow(ov1), .underflow(un1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic p, input logic [7:0] d, input logic o, input logic acc);
      push = p;
      d_in = d;
      pop  = o;
      if (p && acc) begin
         q0.push_back(d);
         q1.push_back(d);
      end
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (pop && dv0) begin
            if (q0.size() == 0) begin
               total++; bad++;
               $display("FAIL fwft_pop: got %0h expected no word", do0);
            end else chk("fwft_pop", {24'd0, do0}, {24'd0, q0.pop_front()});
         end
         if (dv1) begin
            if (q1.size() == 0) begin
               total++; bad++;
               $display("FAIL reg_pop: got %0h expected no word", do1);
            end else chk("reg_pop", {24'd0, do1}, {24'd0, q1.pop_front()});
         end
      end
   end

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; d_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_level", lv0, 0);
      chk("rst_flags", {em0, fu0, af0, ae0, ov0, un0}, 6'b100100);
      chk("rst_out_fwft", {dv0, do0}, 0);
      chk("rst_out_reg", {dv1, do1, em1}, 10'h001);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
         chk("fill_level", lv0, i);
         chk("fill_flags", {fu0, af0, ae0, em0}, {i == 5, i >= 4, i <= 1, 1'b0});
      end
      step(1'b1, 8'hAA, 1'b1, 1'b1);
      chk("full_pushpop_level", lv0, 5);
      chk("full_pushpop_ovf", ov0, 0);
      step(1'b1, 8'hBB, 1'b0, 1'b0);
      chk("full_push_level", lv0, 5);
      chk("full_push_ovf", {ov0, ov1}, 2'b11);
      chk("reg_hold", {dv1, do1}, 9'h011);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_sticky", ov0, 1);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_empty", {em0, lv0}, 4'b1000);
      step(1'b1, 8'h3C, 1'b1, 1'b1);
      chk("empty_pushpop_unf", {un0, un1}, 2'b11);
      chk("empty_pushpop_level", lv0, 1);
      chk("empty_pushpop_out", {dv0, do0}, 9'h13C);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h80, 1'b0, 1'b1);
      step(1'b1, 8'h81, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b1);
         chk("wrap_level", lv0, 2);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_drained", {em0, lv0}, 4'b1000);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b1);
      chk("reg_before_pop", dv1, 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("reg_after_pop", {dv1, do1}, 9'h15A);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("reg_hold_5a", {dv1, do1}, 9'h05A);
      for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
      chk("pre_rst_state", {lv0, ov0}, 4'b0111);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q0.delete();
      q1.delete();
      chk("mid_rst_level", {lv0, lv1}, 0);
      chk("mid_rst_flags", {em0, fu0, ov0, un0, dv0, dv1}, 6'b100000);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("post_rst_out", {dv0, do0}, 9'h177);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fwft_sb_drained", q0.size(), 0);
      chk("reg_sb_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
